servo_sequencer: RTL and testbench
==================================

SERVO_SEQUENCER -- requirements
Module: servo_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, clk_100M cycles per dwell tick (10 ms).
REQ-002 SHALL have parameter DEPTH, default 8, waypoint table entries; fixed at 8 in this release.
REQ-003 SHALL have port clk_100M  input  1  system clock, 100 MHz, the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  table write strobe.
REQ-006 SHALL have port wr_addr  input  3  table write index.
REQ-007 SHALL have port wr_data  input  20  {dwell[19:12], speed[11:8], angle[7:0]}.
REQ-008 SHALL have port num_steps  input  4  active entries, valid 1-8.
REQ-009 SHALL have port loop  input  1  1 = restart at entry 0 after the last entry.
REQ-010 SHALL have port start  input  1  single-cycle run request.
REQ-011 SHALL have port stop  input  1  single-cycle abort request.
REQ-012 SHALL have port angle  output  8  to servo_controller angle, 0-180.
REQ-013 SHALL have port speed  output  4  to servo_controller speed, 0-10.
REQ-014 SHALL have port servo_en  output  1  to servo_controller en; equals busy.
REQ-015 SHALL have port busy  output  1  high in any state except IDLE.
REQ-016 SHALL have port step_idx  output  3  index of the entry currently applied.
REQ-017 SHALL have port done  output  1  one-cycle pulse when a non-loop run completes.

Function
REQ-018 SHALL clamp on write: angle>180 stored as 180; speed>10 stored as 10; dwell stored unchanged.
REQ-019 SHALL accept writes in every state; a rewritten entry takes effect the next time it is loaded.
REQ-020 SHALL implement states IDLE, LOAD, DWELL and ADVANCE.
REQ-021 In IDLE, start with num_steps in 1-8 and stop low SHALL set step_idx=0 and go to LOAD next cycle; otherwise start is ignored.
REQ-022 SHALL ignore start while busy.
REQ-023 In LOAD, angle/speed SHALL register table[step_idx], the dwell counter SHALL load max(dwell,1), the tick prescaler SHALL clear, and the state goes to DWELL; outputs are valid 2 cycles after start is sampled.
REQ-024 In DWELL, the counter SHALL decrement on each tick; the tick fires every TICK_DIV cycles counted from LOAD.
REQ-025 SHALL leave DWELL for ADVANCE on the tick that takes the counter from 1 to 0, so entry dwell N (N>=1) holds outputs N*TICK_DIV+2 cycles.
REQ-026 In ADVANCE with step_idx<num_steps-1, SHALL increment step_idx and go to LOAD.
REQ-027 In ADVANCE at the last entry with loop=1, SHALL set step_idx=0 and go to LOAD.
REQ-028 In ADVANCE at the last entry with loop=0, SHALL pulse done for one cycle and go to IDLE.
REQ-029 SHALL sample num_steps and loop only in ADVANCE; if step_idx>=num_steps there, SHALL treat the entry as last.
REQ-030 Stop in any non-IDLE state SHALL go to IDLE next cycle with no done pulse; angle, speed and step_idx hold; servo_en drops.
REQ-031 When start and stop are high in the same cycle, stop SHALL win.
REQ-032 SHALL keep angle and speed in IDLE at their last value.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE, angle=0, speed=0, servo_en=0, busy=0, step_idx=0, done=0, dwell counter=0 and prescaler=0.
REQ-034 Reset SHALL clear table contents to 0; reset mid-run SHALL abort without a done pulse.

Structure
REQ-035 SHALL take MAX_ANGLE=180, MAX_SPEED=10, the field widths of wr_data and the state encoding from the shared servo_pkg package.
REQ-036 SHALL implement the prescaler as sub-module tick_gen (parameter TICK_DIV, input clear, output one-cycle tick).

Verification (TICK_DIV=4)
REQ-037 Write entries {a=0,s=5,d=2} and {a=180,s=10,d=1}, num_steps=2, loop=0, pulse start -> entry 0 outputs held 10 cycles, entry 1 held 6 cycles, one done pulse, busy drops.
REQ-038 Write angle=200, speed=15 -> outputs show 180 and 10 when that entry runs.
REQ-039 With loop=1, num_steps=2 -> step_idx sequence 0,1,0,1 and no done; stop mid-DWELL -> IDLE next cycle, angle held, servo_en=0.
REQ-040 Start and stop in the same cycle -> no run; start with num_steps=0 or 9 -> no run.
REQ-041 Entry with dwell=0 -> held 6 cycles, same as dwell=1.
REQ-042 Assert rst_n low mid-DWELL, asynchronously between clock edges -> all outputs 0 immediately, no done pulse.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared servo definitions: waypoint field layout, clamp limits and the sequencer state encoding.
package servo_pkg;

    localparam int ANGLE_W = 8;
    localparam int SPEED_W = 4;
    localparam int DWELL_W = 8;
    localparam int ENTRY_W = DWELL_W + SPEED_W + ANGLE_W;

    localparam logic [ANGLE_W-1:0] MAX_ANGLE = 8'd180;
    localparam logic [SPEED_W-1:0] MAX_SPEED = 4'd10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        DWELL   = 2'd2,
        ADVANCE = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [DWELL_W-1:0] dwell;
        logic [SPEED_W-1:0] speed;
        logic [ANGLE_W-1:0] angle;
    } waypoint_t;

    // Saturate angle and speed to what the servo controller accepts; dwell passes through.
    function automatic waypoint_t clamp_entry(input waypoint_t raw);
        waypoint_t c;
        c = raw;
        if (raw.angle > MAX_ANGLE) c.angle = MAX_ANGLE;
        if (raw.speed > MAX_SPEED) c.speed = MAX_SPEED;
        return c;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Dwell prescaler: one-cycle tick every TICK_DIV cycles, restarted by clear.
module tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk_100M,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear || r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = !clear && (r_count == LAST);

endmodule

// File: rtl/servo_sequencer.sv
// Waypoint sequencer: plays a clamped table of {angle, speed, dwell} entries into a servo controller.
module servo_sequencer
    import servo_pkg::*;
#(
    parameter int TICK_DIV = 1000000,
    parameter int DEPTH    = 8
) (
    input  logic               clk_100M,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [3:0]         num_steps,
    input  logic               loop,
    input  logic               start,
    input  logic               stop,
    output logic [ANGLE_W-1:0] angle,
    output logic [SPEED_W-1:0] speed,
    output logic               servo_en,
    output logic               busy,
    output logic [2:0]         step_idx,
    output logic               done
);

    seq_state_t         r_state;
    seq_state_t         w_next_state;
    waypoint_t          r_table [DEPTH];
    logic [ANGLE_W-1:0] r_angle;
    logic [SPEED_W-1:0] r_speed;
    logic [2:0]         r_step_idx;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic               r_done;

    waypoint_t          w_entry;
    logic [DWELL_W-1:0] w_dwell_load;
    logic               w_tick;
    logic               w_steps_valid;
    logic               w_last;
    logic               w_abort;

    assign w_entry       = r_table[r_step_idx];
    assign w_dwell_load  = (w_entry.dwell == '0) ? DWELL_W'(1) : w_entry.dwell;
    assign w_steps_valid = (num_steps != 4'd0) && (num_steps <= 4'd8);
    // An out-of-range step index (num_steps shrunk mid-run) is treated as the last entry.
    assign w_last        = ({1'b0, r_step_idx} + 4'd1) >= num_steps;
    assign w_abort       = stop && (r_state != IDLE);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk_100M(clk_100M),
        .rst_n   (rst_n),
        .clear   (r_state == LOAD),
        .tick    (w_tick)
    );

    // NOTE: the table is reset explicitly so a post-reset run sees zeroed entries, not stale data.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
        end else if (wr_en) begin
            r_table[wr_addr] <= clamp_entry(waypoint_t'(wr_data));
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: next state defaults to the current state first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start && !stop && w_steps_valid) w_next_state = LOAD;
            LOAD:    w_next_state = DWELL;
            DWELL:   if (w_tick && r_dwell_cnt <= DWELL_W'(1)) w_next_state = ADVANCE;
            ADVANCE: w_next_state = (w_last && !loop) ? IDLE : LOAD;
            default: w_next_state = IDLE;
        endcase
        if (w_abort) w_next_state = IDLE;
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_angle     <= '0;
            r_speed     <= '0;
            r_step_idx  <= '0;
            r_dwell_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == ADVANCE) && (w_next_state == IDLE) && !stop;
            if (!w_abort) begin
                if (r_state == IDLE && w_next_state == LOAD) r_step_idx <= '0;
                if (r_state == LOAD) begin
                    r_angle     <= w_entry.angle;
                    r_speed     <= w_entry.speed;
                    r_dwell_cnt <= w_dwell_load;
                end
                if (r_state == DWELL && w_tick && r_dwell_cnt != '0) r_dwell_cnt <= r_dwell_cnt - 1'b1;
                if (r_state == ADVANCE && w_next_state == LOAD) r_step_idx <= w_last ? 3'd0 : r_step_idx + 3'd1;
            end
        end
    end

    assign angle    = r_angle;
    assign speed    = r_speed;
    assign busy     = (r_state != IDLE);
    assign servo_en = busy;
    assign step_idx = r_step_idx;
    assign done     = r_done;

endmodule

// File: tb/tb_servo_sequencer.sv
// Self-checking bench for servo_sequencer: directed scenarios plus randomized runs against a cycle-trace model.
module tb_servo_sequencer;

    localparam int TDIV = 4;

    logic        clk_100M = 1'b0;
    logic        rst_n    = 1'b0;
    logic        wr_en    = 1'b0;
    logic [2:0]  wr_addr  = '0;
    logic [19:0] wr_data  = '0;
    logic [3:0]  num_steps = '0;
    logic        loop  = 1'b0;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic [7:0]  angle;
    logic [3:0]  speed;
    logic        servo_en;
    logic        busy;
    logic [2:0]  step_idx;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: raw table contents, currently applied outputs, and the expected per-cycle trace.
    logic [19:0] m_tbl [8];
    logic [7:0]  m_angle = '0;
    logic [3:0]  m_speed = '0;
    int          m_seq [$];
    logic [17:0] m_exp [$];

    always #5 clk_100M = ~clk_100M;

    servo_sequencer #(
        .TICK_DIV(TDIV),
        .DEPTH   (8)
    ) dut (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .num_steps(num_steps),
        .loop     (loop),
        .start    (start),
        .stop     (stop),
        .angle    (angle),
        .speed    (speed),
        .servo_en (servo_en),
        .busy     (busy),
        .step_idx (step_idx),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] obs();
        return {busy, servo_en, step_idx, angle, speed, done};
    endfunction

    function automatic logic [17:0] mk(input logic b, input logic [2:0] st, input logic [7:0] a,
                                      input logic [3:0] s, input logic d);
        return {b, b, st, a, s, d};
    endfunction

    function automatic logic [7:0] clamp_a(input logic [19:0] e);
        return (e[7:0] > 8'd180) ? 8'd180 : e[7:0];
    endfunction

    function automatic logic [3:0] clamp_s(input logic [19:0] e);
        return (e[11:8] > 4'd10) ? 4'd10 : e[11:8];
    endfunction

    // Each entry occupies one LOAD cycle (old outputs), then dwell*TDIV DWELL cycles plus one
    // ADVANCE cycle with the new outputs; a finished non-loop run shows done in the first idle cycle.
    task automatic build_trace(input bit fin);
        int k;
        int n;
        m_exp.delete();
        foreach (m_seq[i]) begin
            k = m_seq[i];
            m_exp.push_back(mk(1'b1, 3'(k), m_angle, m_speed, 1'b0));
            m_angle = clamp_a(m_tbl[k]);
            m_speed = clamp_s(m_tbl[k]);
            n = (m_tbl[k][19:12] == 8'd0) ? 1 : int'(m_tbl[k][19:12]);
            repeat (n * TDIV + 1) m_exp.push_back(mk(1'b1, 3'(k), m_angle, m_speed, 1'b0));
        end
        if (fin) begin
            k = m_seq[m_seq.size() - 1];
            m_exp.push_back(mk(1'b0, 3'(k), m_angle, m_speed, 1'b1));
            m_exp.push_back(mk(1'b0, 3'(k), m_angle, m_speed, 1'b0));
        end
    endtask

    task automatic write_entry(input int a, input logic [19:0] d);
        @(posedge clk_100M);
        #1;
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_data = d;
        m_tbl[a] = d;
        @(posedge clk_100M);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic with_stop);
        @(posedge clk_100M);
        #1;
        start = 1'b1;
        stop  = with_stop;
        @(posedge clk_100M);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic run_trace(input string tag, input bit fin);
        build_trace(fin);
        pulse_start(1'b0);
        foreach (m_exp[i]) begin
            @(negedge clk_100M);
            check(tag, 32'(obs()), 32'(m_exp[i]));
        end
    endtask

    task automatic expect_no_run(input string tag);
        repeat (3) begin
            @(negedge clk_100M);
            check(tag, 32'({busy, servo_en, done}), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_tbl[i] = '0;

        #12;
        check("reset_outputs", 32'(obs()), 32'd0);
        #10;
        rst_n = 1'b1;

        // Two-entry run: 10 cycles then 6 cycles, single done pulse.
        write_entry(0, {8'd2, 4'd5, 8'd0});
        write_entry(1, {8'd1, 4'd10, 8'd180});
        num_steps = 4'd2;
        loop      = 1'b0;
        m_seq = '{0, 1};
        run_trace("two_entry", 1'b1);

        // Out-of-range angle/speed with zero dwell: clamped, held like dwell=1.
        write_entry(0, {8'd0, 4'd15, 8'd200});
        num_steps = 4'd1;
        m_seq = '{0};
        run_trace("clamp_dwell0", 1'b1);

        pulse_start(1'b1);
        expect_no_run("start_with_stop");
        num_steps = 4'd0;
        pulse_start(1'b0);
        expect_no_run("num_steps_0");
        num_steps = 4'd9;
        pulse_start(1'b0);
        expect_no_run("num_steps_9");

        // Looping run, then abort mid-DWELL.
        write_entry(0, {8'd1, 4'd3, 8'd45});
        write_entry(1, {8'd2, 4'd7, 8'd135});
        num_steps = 4'd2;
        loop      = 1'b1;
        m_seq = '{0, 1, 0, 1};
        run_trace("loop", 1'b0);
        repeat (3) @(posedge clk_100M);
        #1;
        stop = 1'b1;
        @(posedge clk_100M);
        #1;
        stop = 1'b0;
        m_angle = clamp_a(m_tbl[0]);
        m_speed = clamp_s(m_tbl[0]);
        @(negedge clk_100M);
        check("stop_mid_dwell", 32'(obs()), 32'(mk(1'b0, 3'd0, m_angle, m_speed, 1'b0)));
        @(negedge clk_100M);
        check("stop_no_done", 32'(obs()), 32'(mk(1'b0, 3'd0, m_angle, m_speed, 1'b0)));
        loop = 1'b0;

        // Randomized non-loop runs over random tables.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++)
                write_entry(i, {8'($urandom_range(0, 3)), 4'($urandom), 8'($urandom)});
            num_steps = 4'($urandom_range(1, 8));
            m_seq.delete();
            for (int i = 0; i < int'(num_steps); i++) m_seq.push_back(i);
            run_trace("random_run", 1'b1);
        end

        // Asynchronous reset in the middle of a dwell, away from any clock edge.
        write_entry(0, {8'd3, 4'd6, 8'd90});
        num_steps = 4'd1;
        pulse_start(1'b0);
        repeat (4) @(posedge clk_100M);
        check("pre_reset_busy", 32'({busy, angle}), 32'({1'b1, 8'd90}));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'(obs()), 32'd0);
        @(negedge clk_100M);
        check("reset_hold", 32'(obs()), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m_tbl[i] = '0;
        m_angle = '0;
        m_speed = '0;
        m_seq = '{0};
        run_trace("post_reset_table", 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
